// File: rtl/traffic_light_ctrl.sv
// Multi-direction traffic light controller: GREEN -> YELLOW -> ALLRED rotation per approach,
// tick-based phase timing, pedestrian green truncation and a flashing-yellow maintenance mode.
module traffic_light_ctrl #(
   parameter int NUM_DIR   = 2,
   parameter int TW        = 8,
   parameter int TICK_DIV  = 50000000,
   parameter int MIN_GREEN = 2,
   parameter int Y_LEVEL   = 100
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [TW-1:0]          g_time,
   input  logic [TW-1:0]          y_time,
   input  logic [TW-1:0]          ar_time,
   input  logic                   flash_mode,
   input  logic [NUM_DIR-1:0]     ped_req,
   output logic [NUM_DIR*8-1:0]   lamp_r,
   output logic [NUM_DIR*8-1:0]   lamp_g,
   output logic [NUM_DIR*8-1:0]   lamp_b,
   output logic [TW-1:0]          cnt_out,
   output logic [1:0]             phase,
   output logic [1:0]             dir
);

   typedef enum logic [1:0] {
      PH_GREEN  = 2'd0,
      PH_YELLOW = 2'd1,
      PH_ALLRED = 2'd2,
      PH_FLASH  = 2'd3
   } phase_t;

   localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [TW-1:0]  MIN_G     = TW'(MIN_GREEN);
   localparam logic [TW-1:0]  ONE       = TW'(1);
   localparam logic [1:0]     LAST_DIR  = 2'(NUM_DIR - 1);
   localparam logic [7:0]     YL        = 8'(Y_LEVEL);

   logic [PW-1:0]         presc_q, presc_d;
   logic                  tick;
   phase_t                phase_q, phase_d;
   logic [1:0]            dir_q, dir_d;
   logic [TW-1:0]         remain_q, remain_d, eff_remain;
   logic                  blink_q, blink_d;
   logic [NUM_DIR-1:0]    ped_hit;
   logic                  ped_act;
   logic [NUM_DIR*8-1:0]  lamp_r_q, lamp_g_q, lamp_b_q;
   logic [NUM_DIR*8-1:0]  lamp_r_d, lamp_g_d, lamp_b_d;

   // A zero duration still has to last one tick so the sequence never stalls.
   function automatic logic [TW-1:0] dur_load(input logic [TW-1:0] t);
      return (t == '0) ? ONE : t;
   endfunction

   assign tick    = (presc_q == PRESC_MAX);
   assign presc_d = tick ? '0 : presc_q + PW'(1);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIR; gi++) begin : g_ped
         assign ped_hit[gi] = ped_req[gi] && (dir_q == 2'(gi));
      end
   endgenerate
   assign ped_act = |ped_hit;

   always_comb begin
      phase_d    = phase_q;
      dir_d      = dir_q;
      remain_d   = remain_q;
      blink_d    = blink_q;
      eff_remain = remain_q;
      if (flash_mode) begin
         phase_d  = PH_FLASH;
         dir_d    = 2'd0;
         remain_d = '0;
         if (phase_q != PH_FLASH) blink_d = 1'b0;
         else if (tick)           blink_d = ~blink_q;
      end else if (phase_q == PH_FLASH) begin
         phase_d  = PH_ALLRED;
         dir_d    = LAST_DIR;
         remain_d = dur_load(ar_time);
         blink_d  = 1'b0;
      end else begin
         // Truncation happens first so a coincident tick counts down from MIN_GREEN.
         if (phase_q == PH_GREEN && ped_act && remain_q > MIN_G) eff_remain = MIN_G;
         remain_d = eff_remain;
         if (tick) begin
            if (eff_remain == ONE) begin
               case (phase_q)
                  PH_GREEN: begin
                     phase_d  = PH_YELLOW;
                     remain_d = dur_load(y_time);
                  end
                  PH_YELLOW: begin
                     phase_d  = PH_ALLRED;
                     remain_d = dur_load(ar_time);
                  end
                  default: begin
                     phase_d  = PH_GREEN;
                     dir_d    = (dir_q == LAST_DIR) ? 2'd0 : dir_q + 2'd1;
                     remain_d = dur_load(g_time);
                  end
               endcase
            end else begin
               remain_d = eff_remain - ONE;
            end
         end
      end
   end

   // Lamp colours are derived from the next state so they change on the same edge as phase.
   generate
      for (gi = 0; gi < NUM_DIR; gi++) begin : g_lamp
         logic [7:0] r_v, g_v;
         always_comb begin
            r_v = 8'hFF;
            g_v = 8'h00;
            case (phase_d)
               PH_GREEN: if (dir_d == 2'(gi)) begin
                  r_v = 8'h00;
                  g_v = 8'hFF;
               end
               PH_YELLOW: if (dir_d == 2'(gi)) begin
                  r_v = YL;
                  g_v = YL;
               end
               PH_FLASH: begin
                  r_v = blink_d ? YL : 8'h00;
                  g_v = blink_d ? YL : 8'h00;
               end
               default: ;
            endcase
         end
         assign lamp_r_d[8*gi +: 8] = r_v;
         assign lamp_g_d[8*gi +: 8] = g_v;
         assign lamp_b_d[8*gi +: 8] = 8'h00;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q  <= '0;
         phase_q  <= PH_ALLRED;
         dir_q    <= LAST_DIR;
         remain_q <= ONE;
         blink_q  <= 1'b0;
         lamp_r_q <= {NUM_DIR{8'hFF}};
         lamp_g_q <= '0;
         lamp_b_q <= '0;
      end else begin
         presc_q  <= presc_d;
         phase_q  <= phase_d;
         dir_q    <= dir_d;
         remain_q <= remain_d;
         blink_q  <= blink_d;
         lamp_r_q <= lamp_r_d;
         lamp_g_q <= lamp_g_d;
         lamp_b_q <= lamp_b_d;
      end
   end

   assign lamp_r  = lamp_r_q;
   assign lamp_g  = lamp_g_q;
   assign lamp_b  = lamp_b_q;
   assign cnt_out = remain_q;
   assign phase   = phase_q;
   assign dir     = dir_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: a behavioural model queues the expected outputs
// for every clock, and an independent monitor pops and compares them after each edge.
module tb_traffic_light_ctrl;

   localparam int ND  = 2;
   localparam int TD  = 4;
   localparam int MG  = 2;
   localparam int YLV = 100;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    g_time, y_time, ar_time;
   logic          flash_mode;
   logic [ND-1:0] ped_req;
   logic [ND*8-1:0] lamp_r, lamp_g, lamp_b;
   logic [7:0]    cnt_out;
   logic [1:0]    phase, dir;

   traffic_light_ctrl #(
      .NUM_DIR(ND), .TW(8), .TICK_DIV(TD), .MIN_GREEN(MG), .Y_LEVEL(YLV)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .g_time(g_time), .y_time(y_time), .ar_time(ar_time),
      .flash_mode(flash_mode), .ped_req(ped_req),
      .lamp_r(lamp_r), .lamp_g(lamp_g), .lamp_b(lamp_b),
      .cnt_out(cnt_out), .phase(phase), .dir(dir)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]      ph;
      logic [1:0]      d;
      logic [7:0]      cnt;
      logic [ND*8-1:0] r;
      logic [ND*8-1:0] g;
      logic [ND*8-1:0] b;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   started  = 1'b0;

   // Reference model: phase 0=G 1=Y 2=AR 3=FLASH, durations looked up by phase index.
   int m_phase, m_dir, m_rem, m_presc;
   bit m_blink;
   int g_v = 3, y_v = 2, ar_v = 1;

   function automatic int dur(input int ph);
      int t;
      t = (ph == 0) ? int'(g_time) : (ph == 1) ? int'(y_time) : int'(ar_time);
      return (t == 0) ? 1 : t;
   endfunction

   task automatic model_step();
      bit tk;
      if (!rst_n) begin
         m_phase = 2; m_dir = ND - 1; m_rem = 1; m_presc = 0; m_blink = 0;
         return;
      end
      tk      = (m_presc == TD - 1);
      m_presc = (m_presc + 1) % TD;
      if (flash_mode) begin
         if (m_phase != 3) m_blink = 0;
         else if (tk)      m_blink = !m_blink;
         m_phase = 3; m_dir = 0; m_rem = 0;
      end else if (m_phase == 3) begin
         m_phase = 2; m_dir = ND - 1; m_rem = dur(2); m_blink = 0;
      end else begin
         if (m_phase == 0 && ped_req[m_dir] && m_rem > MG) m_rem = MG;
         if (tk) begin
            if (m_rem == 1) begin
               m_phase = (m_phase + 1) % 3;
               if (m_phase == 0) m_dir = (m_dir + 1) % ND;
               m_rem = dur(m_phase);
            end else begin
               m_rem = m_rem - 1;
            end
         end
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.ph  = 2'(m_phase);
      e.d   = 2'(m_dir);
      e.cnt = 8'(m_rem);
      for (int d = 0; d < ND; d++) begin
         int rv, gv;
         rv = 255; gv = 0;
         if (m_phase == 0 && d == m_dir) begin rv = 0;   gv = 255; end
         if (m_phase == 1 && d == m_dir) begin rv = YLV; gv = YLV; end
         if (m_phase == 3) begin rv = m_blink ? YLV : 0; gv = rv; end
         e.r[8*d +: 8] = 8'(rv);
         e.g[8*d +: 8] = 8'(gv);
         e.b[8*d +: 8] = 8'h00;
      end
      return e;
   endfunction

   task automatic cycle(input bit r, input bit f, input logic [ND-1:0] p);
      @(negedge clk);
      rst_n = r; flash_mode = f; ped_req = p;
      g_time = 8'(g_v); y_time = 8'(y_v); ar_time = 8'(ar_v);
      model_step();
      sb_q.push_back(model_out());
      started = 1'b1;
   endtask

   // Idles until the model reaches the requested state; rem<0 means any count.
   task automatic wait_for(input int ph, input int d, input int rem, input bit no_tick, input string name);
      int k;
      for (k = 0; k < 400; k++) begin
         if (m_phase == ph && m_dir == d && (rem < 0 || m_rem == rem) &&
             (!no_tick || m_presc != TD - 1)) break;
         cycle(1'b1, 1'b0, '0);
      end
      if (k == 400) begin
         n_checks++; n_fail++;
         $display("FAIL wait_%s: state not reached within 400 clocks", name);
      end
   endtask

   initial begin : monitor
      exp_t e;
      logic [1:0] last_ph = 2'bxx, last_d = 2'bxx;
      forever begin
         @(posedge clk);
         #1;
         if (started) begin
            if (sb_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
               e = sb_q.pop_front();
               n_checks++;
               if ({phase, dir, cnt_out} !== {e.ph, e.d, e.cnt}) begin
                  n_fail++;
                  $display("FAIL state at %0t: got phase=%0d dir=%0d cnt=%0d, want phase=%0d dir=%0d cnt=%0d",
                           $time, phase, dir, cnt_out, e.ph, e.d, e.cnt);
               end
               n_checks++;
               if ({lamp_r, lamp_g, lamp_b} !== {e.r, e.g, e.b}) begin
                  n_fail++;
                  $display("FAIL lamps at %0t: got r=%h g=%h b=%h, want r=%h g=%h b=%h",
                           $time, lamp_r, lamp_g, lamp_b, e.r, e.g, e.b);
               end
               if (phase !== last_ph || dir !== last_d) begin
                  $display("t=%0t phase=%0d dir=%0d cnt=%0d r=%h g=%h", $time, phase, dir, cnt_out, lamp_r, lamp_g);
                  last_ph = phase; last_d = dir;
               end
            end
         end
      end
   end

   initial begin : driver
      bit fl;
      bit r;
      logic [ND-1:0] p;
      rst_n = 1'b0; flash_mode = 1'b0; ped_req = '0;
      g_time = 8'd3; y_time = 8'd2; ar_time = 8'd1;

      repeat (3) cycle(1'b0, 1'b0, '0);
      repeat (70) cycle(1'b1, 1'b0, '0);

      // Pedestrian on the active approach truncates, on the other approach is ignored.
      wait_for(0, 0, 3, 1'b1, "g0_ped0");
      cycle(1'b1, 1'b0, 2'b01);
      repeat (20) cycle(1'b1, 1'b0, '0);
      wait_for(0, 0, 3, 1'b1, "g0_ped1");
      cycle(1'b1, 1'b0, 2'b10);
      repeat (20) cycle(1'b1, 1'b0, '0);

      // Flash entry from YELLOW(1), several blink ticks, then exit via ALLRED(1).
      wait_for(1, 1, -1, 1'b0, "y1_flash");
      repeat (13) cycle(1'b1, 1'b1, '0);
      repeat (20) cycle(1'b1, 1'b0, '0);

      y_v = 0;
      repeat (50) cycle(1'b1, 1'b0, '0);
      y_v = 2;

      wait_for(0, 1, 2, 1'b0, "g1_reset");
      cycle(1'b0, 1'b0, '0);
      repeat (20) cycle(1'b1, 1'b0, '0);

      // Randomised soak: durations (including 0), pedestrians, flash and occasional resets.
      fl = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 59) == 0) fl = !fl;
         if ($urandom_range(0, 19) == 0) begin
            g_v  = $urandom_range(0, 5);
            y_v  = $urandom_range(0, 3);
            ar_v = $urandom_range(0, 2);
         end
         r = ($urandom_range(0, 249) != 0);
         p = ($urandom_range(0, 3) == 0) ? ND'($urandom_range(0, 3)) : '0;
         cycle(r, fl, p);
      end

      @(posedge clk);
      #2;
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected entries left unchecked, want 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIR, default 2, number of approach directions (2..4).
REQ-002 SHALL have parameter TW, default 8, width of time inputs and countdown.
REQ-003 SHALL have parameter TICK_DIV, default 50000000, clocks per timing tick (>=1).
REQ-004 SHALL have parameter MIN_GREEN, default 2, green remainder after pedestrian truncation (>=1).
REQ-005 SHALL have parameter Y_LEVEL, default 100, R and G intensity for yellow.
REQ-006 SHALL have port clk  input  1  single clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-008 SHALL have port g_time / y_time / ar_time  input  TW each  green / yellow / all-red durations in ticks.
REQ-009 SHALL have port flash_mode  input  1  level; high selects flashing-yellow maintenance mode.
REQ-010 SHALL have port ped_req  input  NUM_DIR  per-direction pedestrian request, level-sampled.
REQ-011 SHALL have port lamp_r / lamp_g / lamp_b  output  NUM_DIR*8 each  per-direction intensity; direction d occupies bits [8d+7:8d].
REQ-012 SHALL have port cnt_out  output  TW  ticks remaining in the current phase.
REQ-013 SHALL have port phase  output  2  0=GREEN, 1=YELLOW, 2=ALLRED, 3=FLASH.
REQ-014 SHALL have port dir  output  2  active direction index.

Function
REQ-015 SHALL run a free-running prescaler 0..TICK_DIV-1; tick is asserted for one clock when the count equals TICK_DIV-1; the count wraps to 0; the prescaler is unaffected by mode.
REQ-016 SHALL sequence GREEN(d) -> YELLOW(d) -> ALLRED(d) -> GREEN((d+1) mod NUM_DIR).
REQ-017 SHALL hold a registered counter remain (TW bits); on a tick with remain==1, the block advances phase; on a tick with remain>1, remain decrements.
REQ-018 SHALL load remain on phase entry from the duration input sampled in the entry cycle; a duration of 0 loads 1.
REQ-019 SHALL register all outputs, with cnt_out=remain, phase and dir reflecting the current state.
REQ-020 SHALL drive lamps in GREEN(d): direction d R=0 G=255 B=0; all other directions R=255 G=0 B=0.
REQ-021 SHALL drive lamps in YELLOW(d): direction d R=Y_LEVEL G=Y_LEVEL B=0; all others red.
REQ-022 SHALL drive lamps in ALLRED: every direction R=255 G=0 B=0.
REQ-023 SHALL truncate remain to MIN_GREEN when ped_req[d] is high in GREEN(d) and remain>MIN_GREEN; a same-cycle tick then decrements from MIN_GREEN, advancing if MIN_GREEN==1.
REQ-024 SHALL ignore ped_req outside GREEN, and ped_req bits of non-active directions.
REQ-025 SHALL enter FLASH on the clock after flash_mode is sampled high, from any state, overriding any same-cycle tick or ped_req.
REQ-026 SHALL, in FLASH, hold remain=0 and dir=0 and toggle a blink bit on every tick; blink=1 drives all directions R=G=Y_LEVEL B=0; blink=0 drives all lamps 0.
REQ-027 SHALL clear blink to 0 on entry to FLASH.
REQ-028 SHALL, when flash_mode is sampled low in FLASH, enter ALLRED(NUM_DIR-1) with remain loaded from ar_time, so GREEN(0) follows.
REQ-029 SHALL treat a duration-input change mid-phase as taking effect only at the next entry into that phase.

Reset
REQ-030 SHALL, while rst_n is sampled low, reset state to ALLRED(NUM_DIR-1) with remain=1, prescaler=0 and blink=0, overriding all other inputs, mid-phase or in FLASH.
REQ-031 SHALL present outputs during and after reset as phase=2, dir=NUM_DIR-1, cnt_out=1 and all lamps R=255 G=0 B=0, until the first tick.

Verification (NUM_DIR=2, TICK_DIV=4, MIN_GREEN=2, Y_LEVEL=100, g=3, y=2, ar=1)
REQ-032 SHALL verify the basic cycle: release reset -> tick at clock 3 enters GREEN(0) with cnt_out=3; phases then run G0 3 ticks, Y0 2 ticks, AR0 1 tick, G1 3 ticks, Y1 2 ticks, AR1 1 tick, then return to G0.
REQ-033 SHALL verify pedestrian truncation: ped_req[0]=1 in GREEN(0) at cnt_out=3 with no tick -> cnt_out=2 next clock; ped_req[1]=1 in the same state -> no change.
REQ-034 SHALL verify flash mode: flash_mode=1 in YELLOW(1) -> next clock phase=3 with lamps all 0; after 1 tick lamps R=G=100 for both directions; after 2 ticks lamps are 0 again.
REQ-035 SHALL verify flash exit: flash_mode=0 in FLASH -> phase=2, dir=1, cnt_out=1; the next tick gives GREEN(0) with cnt_out=3.
REQ-036 SHALL verify zero duration and reset: y_time=0 -> YELLOW lasts exactly 1 tick; rst_n=0 for one clock during GREEN(1) at cnt_out=2 -> phase=2, dir=1, cnt_out=1, all lamps red.
